// File: rtl/skolem_pkg.sv
// Shared types and constants for the Skolem sweep controller and its candidate counter.
package skolem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEval = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic MODE_WITNESS = 1'b0;
    localparam logic MODE_REALIZE = 1'b1;

    // One extra bit so a full 2^(NX+NI) sweep count never overflows.
    function automatic int unsigned tried_width(int unsigned nx, int unsigned ni);
        return nx + ni + 1;
    endfunction

endpackage

// File: rtl/skolem_cand_counter.sv
// Nested (cand_x, cand_i) candidate counter; i is the inner digit and resets when x advances.
module skolem_cand_counter #(
    parameter int unsigned NX = 4,
    parameter int unsigned NI = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [NX-1:0] load_x,
    input  logic          en,
    input  logic          x_step,
    output logic [NX-1:0] cand_x,
    output logic [NI-1:0] cand_i,
    output logic          i_last,
    output logic          x_last
);

    assign i_last = &cand_i;
    assign x_last = &cand_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_x <= '0;
            cand_i <= '0;
        end else if (load) begin
            cand_x <= load_x;
            cand_i <= '0;
        end else if (en) begin
            // Saturate rather than wrap; the controller never asks past all-ones.
            if (x_step) begin
                if (!x_last) begin
                    cand_x <= cand_x + NX'(1);
                    cand_i <= '0;
                end
            end else if (!i_last) begin
                cand_i <= cand_i + NI'(1);
            end
        end
    end

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Sequencer that walks candidate (x, i) assignments through a Skolem formula instance.
module skolem_sweep_ctrl
    import skolem_pkg::*;
#(
    parameter int unsigned NX       = 4,
    parameter int unsigned NI       = 9,
    parameter int unsigned EVAL_LAT = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             mode,
    input  logic [NX-1:0]                    x_in,
    input  logic                             abort,
    output logic [NX-1:0]                    cand_x,
    output logic [NI-1:0]                    cand_i,
    input  logic                             fm_out,
    output logic                             busy,
    output logic                             done,
    output logic                             found,
    output logic [NI-1:0]                    witness,
    output logic [NX-1:0]                    fail_x,
    output logic [tried_width(NX, NI)-1:0]   tried
);

    localparam int unsigned TW = tried_width(NX, NI);
    localparam int unsigned WW = (EVAL_LAT > 0) ? $clog2(EVAL_LAT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(EVAL_LAT);

    state_e        state;
    logic          mode_q;
    logic [WW-1:0] wait_cnt;
    logic          i_last;
    logic          x_last;
    logic          sample;
    logic          cnt_load;
    logic          cnt_en;
    logic          cnt_x_step;
    logic [NX-1:0] load_x;

    always_comb begin
        cnt_load   = (state == StIdle) && start && !abort;
        load_x     = (mode == MODE_REALIZE) ? '0 : x_in;
        sample     = (state == StEval) && !abort && (wait_cnt == WAIT_LAST);
        cnt_en     = 1'b0;
        cnt_x_step = 1'b0;
        if (sample) begin
            if ((mode_q == MODE_REALIZE) && fm_out && !x_last) begin
                cnt_en     = 1'b1;
                cnt_x_step = 1'b1;
            end else if (!fm_out && !i_last) begin
                cnt_en = 1'b1;
            end
        end
    end

    skolem_cand_counter #(
        .NX(NX),
        .NI(NI)
    ) u_cand_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .load_x (load_x),
        .en     (cnt_en),
        .x_step (cnt_x_step),
        .cand_x (cand_x),
        .cand_i (cand_i),
        .i_last (i_last),
        .x_last (x_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            mode_q   <= MODE_WITNESS;
            wait_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            found    <= 1'b0;
            witness  <= '0;
            fail_x   <= '0;
            tried    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && !abort) begin
                        mode_q   <= mode;
                        wait_cnt <= '0;
                        found    <= 1'b0;
                        witness  <= '0;
                        fail_x   <= '0;
                        tried    <= '0;
                        busy     <= 1'b1;
                        state    <= StEval;
                    end
                end
                StEval: begin
                    if (abort) begin
                        // Partial tried count is kept for inspection.
                        state    <= StIdle;
                        busy     <= 1'b0;
                        wait_cnt <= '0;
                        found    <= 1'b0;
                        witness  <= '0;
                        fail_x   <= '0;
                    end else if (wait_cnt != WAIT_LAST) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end else begin
                        wait_cnt <= '0;
                        tried    <= tried + TW'(1);
                        if (mode_q == MODE_WITNESS) begin
                            if (fm_out) begin
                                witness <= cand_i;
                                found   <= 1'b1;
                                state   <= StDone;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else if (i_last) begin
                                witness <= '0;
                                found   <= 1'b0;
                                state   <= StDone;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            if (fm_out) begin
                                witness <= cand_i;
                                if (x_last) begin
                                    found <= 1'b1;
                                    state <= StDone;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else if (i_last) begin
                                fail_x <= cand_x;
                                found  <= 1'b0;
                                state  <= StDone;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                            end
                        end
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Scoreboard bench for skolem_sweep_ctrl using combinational formula stubs at two latencies.
module tb_skolem_sweep_ctrl;

    localparam int NX = 4;
    localparam int NI = 9;
    localparam int TW = NX + NI + 1;

    typedef struct {
        logic          found;
        logic [NI-1:0] witness;
        logic [NX-1:0] fail_x;
        logic [TW-1:0] tried;
        int            cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start2, mode, abort, sel;
    logic [NX-1:0] x_in;
    logic [NX-1:0] cx0, cx2, fx0, fx2;
    logic [NI-1:0] ci0, ci2, w0, w2;
    logic b0, b2, dn0, dn2, f0, f2, fm0, fm2;
    logic [TW-1:0] tr0, tr2;
    int stub0, stub2;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic stub_fn(int s, logic [NX-1:0] x, logic [NI-1:0] i);
        case (s)
            1:       return i == 9'h0A5;
            2:       return i == ({5'd0, x} + 9'd1);
            3:       return (i == 9'd0) && (x != 4'h6);
            default: return 1'b0;
        endcase
    endfunction

    assign fm0 = stub_fn(stub0, cx0, ci0);
    assign fm2 = stub_fn(stub2, cx2, ci2);

    skolem_sweep_ctrl #(.NX(NX), .NI(NI), .EVAL_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode), .x_in(x_in), .abort(abort),
        .cand_x(cx0), .cand_i(ci0), .fm_out(fm0), .busy(b0), .done(dn0), .found(f0),
        .witness(w0), .fail_x(fx0), .tried(tr0)
    );

    skolem_sweep_ctrl #(.NX(NX), .NI(NI), .EVAL_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .x_in(x_in), .abort(abort),
        .cand_x(cx2), .cand_i(ci2), .fm_out(fm2), .busy(b2), .done(dn2), .found(f2),
        .witness(w2), .fail_x(fx2), .tried(tr2)
    );

    logic [NX-1:0] s_cx, s_fx;
    logic [NI-1:0] s_ci, s_w;
    logic          s_busy, s_done, s_found;
    logic [TW-1:0] s_tried;
    assign s_cx    = sel ? cx2 : cx0;
    assign s_ci    = sel ? ci2 : ci0;
    assign s_fx    = sel ? fx2 : fx0;
    assign s_w     = sel ? w2 : w0;
    assign s_busy  = sel ? b2 : b0;
    assign s_done  = sel ? dn2 : dn0;
    assign s_found = sel ? f2 : f0;
    assign s_tried = sel ? tr2 : tr0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(string tag);
        check_eq({tag, ".cand_x"}, 32'(s_cx), 0);
        check_eq({tag, ".cand_i"}, 32'(s_ci), 0);
        check_eq({tag, ".busy"}, 32'(s_busy), 0);
        check_eq({tag, ".done"}, 32'(s_done), 0);
        check_eq({tag, ".found"}, 32'(s_found), 0);
        check_eq({tag, ".witness"}, 32'(s_w), 0);
        check_eq({tag, ".fail_x"}, 32'(s_fx), 0);
        check_eq({tag, ".tried"}, 32'(s_tried), 0);
    endtask

    task automatic launch(logic s, logic m, logic [NX-1:0] x, logic push, exp_t e,
                          output int t0);
        @(negedge clk);
        sel  = s;
        mode = m;
        x_in = x;
        if (s) start2 = 1'b1;
        else   start0 = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        t0     = cyc;
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(string tag, int t0, int limit, logic [NX-1:0] hold_x, logic chk_hold);
        exp_t e;
        int   bad;
        bad = 0;
        while (!s_done && (cyc - t0) < limit) begin
            if (chk_hold && s_cx !== hold_x) bad++;
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        check_eq({tag, ".done_seen"}, 32'(s_done), 1);
        check_eq({tag, ".done_cycle"}, 32'(cyc - t0 + 1), 32'(e.cycle));
        check_eq({tag, ".busy_in_done"}, 32'(s_busy), 0);
        check_eq({tag, ".found"}, 32'(s_found), 32'(e.found));
        check_eq({tag, ".witness"}, 32'(s_w), 32'(e.witness));
        check_eq({tag, ".fail_x"}, 32'(s_fx), 32'(e.fail_x));
        check_eq({tag, ".tried"}, 32'(s_tried), 32'(e.tried));
        if (chk_hold) check_eq({tag, ".cand_x_hold_errs"}, 32'(bad), 0);
        @(posedge clk);
        #1;
        check_eq({tag, ".done_one_cycle"}, 32'(s_done), 0);
        check_eq({tag, ".found_held"}, 32'(s_found), 32'(e.found));
        check_eq({tag, ".tried_held"}, 32'(s_tried), 32'(e.tried));
    endtask

    initial begin
        int t0;
        int pulses;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        abort  = 1'b0;
        mode   = 1'b0;
        x_in   = '0;
        sel    = 1'b0;
        stub0  = 0;
        stub2  = 0;
        #2;
        check_zero("reset0");
        sel = 1'b1;
        #1;
        check_zero("reset2");
        #19 rst_n = 1'b1;

        // Mode 0 hit on candidate 0x0A5
        stub0 = 1;
        launch(1'b0, 1'b0, 4'h3, 1'b1, '{1'b1, 9'h0A5, 4'h0, 14'd166, 167}, t0);
        check_eq("m0_hit.busy_after_start", 32'(s_busy), 1);
        check_eq("m0_hit.cand_i_start", 32'(s_ci), 0);
        wait_done("m0_hit", t0, 400, 4'h3, 1'b1);

        // Mode 0 exhaustive miss
        stub0 = 0;
        launch(1'b0, 1'b0, 4'h9, 1'b1, '{1'b0, 9'h000, 4'h0, 14'd512, 513}, t0);
        wait_done("m0_miss", t0, 1000, 4'h9, 1'b1);
        check_eq("m0_miss.cand_i_last", 32'(s_ci), 32'h1FF);

        // Mode 1 realizable with 3-cycle holds
        stub2 = 2;
        launch(1'b1, 1'b1, 4'hC, 1'b1, '{1'b1, 9'h010, 4'h0, 14'd152, 457}, t0);
        check_eq("m1_ok.cand_x_start", 32'(s_cx), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("m1_ok.hold_cand_i", 32'(s_ci), 0);
        @(posedge clk);
        #1;
        check_eq("m1_ok.next_cand_i", 32'(s_ci), 1);
        wait_done("m1_ok", t0, 1000, 4'h0, 1'b0);

        // Mode 1 unrealizable at x=6, with an ignored start while busy
        stub2 = 3;
        launch(1'b1, 1'b1, 4'h0, 1'b1, '{1'b0, 9'h000, 4'h6, 14'd518, 1555}, t0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        start2 = 1'b1;
        mode   = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
        #4;
        wait_done("m1_fail", t0, 2000, 4'h0, 1'b0);

        // Abort at tried=50
        stub0 = 0;
        launch(1'b0, 1'b0, 4'h1, 1'b0, '{1'b0, 9'h000, 4'h0, 14'd0, 0}, t0);
        while (s_tried != 14'd50 && (cyc - t0) < 200) begin
            @(posedge clk);
            #1;
        end
        check_eq("abort.tried_reached", 32'(s_tried), 50);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_eq("abort.busy", 32'(s_busy), 0);
        check_eq("abort.found", 32'(s_found), 0);
        check_eq("abort.tried", 32'(s_tried), 50);
        pulses = 0;
        repeat (6) begin
            if (s_done) pulses++;
            @(posedge clk);
            #1;
        end
        check_eq("abort.no_done", 32'(pulses), 0);
        check_eq("abort.tried_after_idle", 32'(s_tried), 50);
        launch(1'b0, 1'b0, 4'h1, 1'b0, '{1'b0, 9'h000, 4'h0, 14'd0, 0}, t0);
        check_eq("restart.cand_i", 32'(s_ci), 0);
        check_eq("restart.tried", 32'(s_tried), 0);
        check_eq("restart.busy", 32'(s_busy), 1);

        // Asynchronous reset mid-run
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        #3 rst_n = 1'b1;

        // start together with abort in IDLE is ignored
        @(negedge clk);
        sel    = 1'b0;
        x_in   = 4'h5;
        start0 = 1'b1;
        abort  = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        abort  = 1'b0;
        check_eq("start_abort.busy", 32'(s_busy), 0);
        check_eq("start_abort.cand_x", 32'(s_cx), 0);
        check_eq("sb.empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/skolem_sweep_ctrl.md
Name: skolem_sweep_ctrl

Overview:
- Sequencer that drives candidate (x, i) assignments into a combinational or pipelined Skolem formula instance and samples its single-bit `out`.
- Mode 0: search for an i-witness for one captured x vector.
- Mode 1: check realizability by sweeping every x vector and requiring a witness for each.
- Sits between the bench/top-level control and the formula instance. Owns all stimulus sequencing for it.

Parameters:
- NX, 4, number of x (universally quantified) formula inputs
- NI, 9, number of i (Skolem output) formula inputs
- EVAL_LAT, 0, cycles from candidate presentation to valid fm_out (0 = combinational formula)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- mode  in  1  0 = single-x witness search, 1 = all-x realizability sweep; captured with start
- x_in  in  NX  x vector for mode 0; captured with start
- abort  in  1  cancel an in-progress sweep
- cand_x  out  NX  registered x vector driven to the formula
- cand_i  out  NI  registered i vector driven to the formula
- fm_out  in  1  formula result for current candidate
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle completion pulse
- found  out  1  mode 0: witness found; mode 1: every x had a witness
- witness  out  NI  mode 0: first satisfying i; mode 1: witness of last x checked
- fail_x  out  NX  mode 1: first x with no witness; 0 otherwise
- tried  out  NX+NI+1  candidates evaluated in the last/current run

Behaviour:
- Reset (async, rst_n=0): state IDLE. Every output is 0: cand_x, cand_i, busy, done, found, witness, fail_x, tried.
- States: IDLE, EVAL, DONE.
- IDLE:
  - On start=1 and abort=0: capture mode and x_in.
  - Load cand_x (x_in for mode 0, 0 for mode 1) and cand_i=0. Clear found, witness, fail_x and tried.
  - Go to EVAL and set busy.
  - start=1 with abort=1 in the same cycle: stay IDLE.
- EVAL:
  - Each candidate is held EVAL_LAT+1 cycles; an internal wait counter runs 0..EVAL_LAT.
  - fm_out is sampled in the last cycle of the hold, and tried increments by 1 per sampled candidate.
- Mode 0:
  - fm_out=1: witness<=cand_i, found<=1, go to DONE.
  - fm_out=0 with cand_i < 2^NI-1: cand_i+1, next candidate.
  - fm_out=0 with cand_i = 2^NI-1: found<=0, witness<=0, go to DONE.
- Mode 1:
  - fm_out=1 with cand_x < 2^NX-1: witness<=cand_i, cand_x+1, cand_i<=0.
  - fm_out=1 with cand_x = 2^NX-1: witness<=cand_i, found<=1, go to DONE.
  - fm_out=0 with cand_i = 2^NI-1: fail_x<=cand_x, found<=0, go to DONE.
  - Otherwise: cand_i+1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. Results hold until the next accepted start or reset. cand_x/cand_i hold their last values.
- Abort: abort=1 in EVAL forces IDLE on the next edge.
  - No done pulse; busy<=0; found, witness and fail_x cleared.
  - tried holds the partial count.
  - abort in IDLE or DONE has no effect.
- start while busy or in DONE is ignored.
- Counters wrap only by design: cand_i/cand_x never increment past their all-ones value.
- tried maximum is 2^(NX+NI), so its NX+NI+1 bits cannot overflow.
- Latency, mode 0, hit on candidate k (EVAL_LAT=0): start sampled at edge e0; candidate k presented in cycle k+1 after e0; done high in cycle k+2.

Decomposition:
- Shared package `skolem_pkg` holds:
  - state enum (IDLE, EVAL, DONE);
  - mode constants (MODE_WITNESS=0, MODE_REALIZE=1);
  - a function for the tried width.
- One natural sub-module, `skolem_cand_counter`: the nested cand_i/cand_x counter with wrap flags (i_last, x_last), an increment enable and an i-reset-on-x-advance input.
- FSM, wait counter and result registers stay in the top.

Test Plan:
- Mode 0, stub fm_out=(cand_i==9'h0A5), EVAL_LAT=0, x_in=4'h3 -> cand_x=3 throughout, done in cycle 167 after start edge, found=1, witness=0x0A5, tried=166.
- Mode 0, stub fm_out=0 -> done after 512 candidates, found=0, witness=0, tried=512, busy low in done cycle.
- Mode 1, stub fm_out=(cand_i==cand_x+1), EVAL_LAT=2 -> found=1, witness=0x010, fail_x=0, tried=sum over x of (x+2)=152, each candidate held 3 cycles.
- Mode 1, stub fails only for x=4'h6 (fm_out=(cand_i==0)&(cand_x!=6)) -> found=0, fail_x=6, tried=6+512=518.
- Abort asserted at tried=50 in mode 0 -> IDLE next edge, no done pulse, found=0, tried=50. A following start restarts with cand_i=0, tried cleared.
- rst_n pulsed low mid-EVAL (asynchronously, between edges) -> all outputs 0 immediately. start during busy and start+abort in IDLE are both ignored.
